// File: rtl/ifu_pkg.sv
// Shared types and width helpers for the instruction fetch unit.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package ifu_pkg;

    localparam int XLEN = 16;

    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } ifu_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } inst_ent_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One extra bit so a count can hold DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ifu_queue.sv
// Circular prefetch buffer of {pc, inst} entries with single-cycle flush.
// Latency: a pushed entry reaches the head the cycle after the push (no bypass).
// Backpressure: push is dropped when full unless a pop happens the same cycle.
module ifu_queue
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_vld,
    input  inst_ent_t               push_dat,
    input  logic                    pop_rdy,
    input  logic                    flush,
    output inst_ent_t               head_dat,
    output logic [cnt_w(DEPTH)-1:0] occ,
    output logic                    empty
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    inst_ent_t        mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             full;
    logic             push_en;
    logic             pop_en;

    assign empty    = (occ == '0);
    assign full     = (occ == CNT_W'(DEPTH));
    assign pop_en   = pop_rdy & ~empty;
    assign push_en  = push_vld & (~full | pop_en);
    assign head_dat = empty ? '0 : mem[head];

    always_ff @(posedge clk) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (push_en) tail <= tail + PTR_W'(1);
            if (pop_en)  head <= head + PTR_W'(1);
            occ <= occ + CNT_W'(push_en) - CNT_W'(pop_en);
        end
    end

    // Storage is not reset; head_dat is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (push_en && !flush) mem[tail] <= push_dat;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns fetch PC, issues imem reads under credit, queues returned instructions.
// Latency: response at cycle N is offered to the core at N+1; IFU_PERF_CNT_EN adds pop/redirect counters.
// Backpressure: requests stop once queued + outstanding entries reach DEPTH; core stalls via inst_ready.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [15:0] inst_data,
    output logic [15:0] inst_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [15:0] perf_fetched,
    output logic [15:0] perf_flushes
`endif
);

    localparam int              CNT_W   = cnt_w(DEPTH);
    localparam logic [CNT_W:0]  DEPTH_V = (CNT_W+1)'(DEPTH);

    ifu_state_t       state;
    ifu_state_t       state_nxt;
    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  resp_pc;
    logic [CNT_W-1:0] outst;
    logic [CNT_W-1:0] outst_nxt;
    logic [CNT_W-1:0] occ;
    logic [CNT_W:0]   inflight;
    logic             rsp_vld;
    logic             hs;
    logic             push_vld;
    logic             pop_vld;
    logic             q_empty;
    inst_ent_t        push_dat;
    inst_ent_t        head_dat;

    // In FLUSH, outst doubles as the count of responses still to be discarded.
    always_comb begin
        inflight  = {1'b0, occ} + {1'b0, outst};
        rsp_vld   = imem_rvalid & (outst != '0);
        imem_req  = rst & (state == FETCH) & ~redirect & (inflight < DEPTH_V);
        hs        = imem_req & imem_gnt;
        push_vld  = rsp_vld & (state == FETCH) & ~redirect;
        outst_nxt = outst + CNT_W'(hs) - CNT_W'(rsp_vld);
        state_nxt = state;
        if (redirect) begin
            state_nxt = (outst_nxt != '0) ? FLUSH : FETCH;
        end else if ((state == FLUSH) && (outst_nxt == '0)) begin
            state_nxt = FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= FETCH;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            outst    <= '0;
        end else begin
            outst <= outst_nxt;
            if (redirect) begin
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
            end else begin
                if (hs)       fetch_pc <= fetch_pc + 16'd1;
                if (push_vld) resp_pc  <= resp_pc + 16'd1;
            end
        end
    end

    assign imem_addr = fetch_pc;
    assign push_dat  = '{pc: resp_pc, inst: imem_rdata};
    assign inst_valid = ~q_empty;
    assign pop_vld   = inst_valid & inst_ready;
    assign inst_pc   = head_dat.pc;
    assign inst_data = head_dat.inst;

    ifu_queue #(.DEPTH(DEPTH)) u_queue (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_rdy  (pop_vld),
        .flush    (redirect),
        .head_dat (head_dat),
        .occ      (occ),
        .empty    (q_empty)
    );

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetched <= '0;
            perf_flushes <= '0;
        end else begin
            if (pop_vld)  perf_fetched <= perf_fetched + 16'd1;
            if (redirect) perf_flushes <= perf_flushes + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a queue-based reference model.
// A second instance with RESET_PC=FFFE covers fetch address wrap.
module tb_instr_fetch_unit;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [15:0] imem_addr, imem_rdata = 16'h0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        inst_valid, inst_ready = 1'b0;
    logic [15:0] inst_data, inst_pc;

    logic        imem_req2, imem_rvalid2 = 1'b0;
    logic [15:0] imem_addr2, imem_rdata2 = 16'h0;
    logic        inst_valid2;
    logic [15:0] inst_data2, inst_pc2;
    logic        gnt2 = 1'b1, ready2 = 1'b1, redirect2 = 1'b0;
    logic [15:0] redirect_pc2 = 16'h0;

`ifdef IFU_PERF_CNT_EN
    logic [15:0] perf_fetched, perf_flushes, perf_fetched2, perf_flushes2;
`endif

    always #5 clk = ~clk;

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc)
`ifdef IFU_PERF_CNT_EN
        , .perf_fetched(perf_fetched), .perf_flushes(perf_flushes)
`endif
    );

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'hFFFE)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_gnt(gnt2),
        .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
        .redirect(redirect2), .redirect_pc(redirect_pc2),
        .inst_valid(inst_valid2), .inst_ready(ready2),
        .inst_data(inst_data2), .inst_pc(inst_pc2)
`ifdef IFU_PERF_CNT_EN
        , .perf_fetched(perf_fetched2), .perf_flushes(perf_flushes2)
`endif
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Stimulus knobs
    bit rst_cmd = 1'b0;
    bit chk_en  = 1'b0;
    int p_gnt = 100, p_ready = 100, p_redir = 0, lat_min = 1, lat_max = 1;
    int arm_mode = 0;

    // Memory model: in-order pending reads with due cycles
    int          mem_due[$];
    logic [15:0] mem_addr[$];
    int          last_due = 0;
    bit          rv2_q = 1'b0;
    logic [15:0] addr2_q = 16'h0;
    int          r2cyc = 0;

    // Reference model
    ent_t        mq[$];
    logic [15:0] m_fetch = 16'h0, m_resp = 16'h0;
    int          m_outst = 0;
    bit          m_flush = 1'b0;
    logic [15:0] m_pops = 16'h0, m_flushes = 16'h0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC35A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        logic        exp_req, exp_vld, rsp, pop;
        logic [15:0] exp_pc, exp_dat, e_wrap;
        int          due;
        @(posedge clk);
        #1;
        cyc++;
        rst = rst_cmd;
        imem_rvalid = rst && (mem_due.size() > 0) && (mem_due[0] <= cyc);
        imem_rdata  = imem_rvalid ? mem_word(mem_addr[0]) : 16'h0;
        imem_gnt    = ($urandom_range(99, 0) < p_gnt);
        inst_ready  = ($urandom_range(99, 0) < p_ready);
        redirect    = 1'b0;
        redirect_pc = 16'($urandom);
        if (rst) begin
            if (arm_mode == 1 && mem_due.size() == 3) begin
                redirect = 1'b1; redirect_pc = 16'h0040; arm_mode = 0;
            end else if (arm_mode == 2 && imem_rvalid && mq.size() > 0 && inst_ready) begin
                redirect = 1'b1; arm_mode = 0;
            end else if ($urandom_range(999, 0) < p_redir) begin
                redirect = 1'b1;
            end
        end
        imem_rvalid2 = rst && rv2_q;
        imem_rdata2  = rv2_q ? mem_word(addr2_q) : 16'h0;
        if (rst) r2cyc++; else r2cyc = 0;
        #1;

        exp_req = rst && !m_flush && !redirect && (mq.size() + m_outst < DEPTH);
        exp_vld = (mq.size() > 0);
        exp_pc  = exp_vld ? mq[0].pc : 16'h0;
        exp_dat = exp_vld ? mq[0].data : 16'h0;
        if (chk_en) begin
            chk("imem_req", 32'(imem_req), 32'(exp_req));
            chk("imem_addr", 32'(imem_addr), 32'(m_fetch));
            chk("inst_valid", 32'(inst_valid), 32'(exp_vld));
            chk("inst_pc", 32'(inst_pc), 32'(exp_pc));
            chk("inst_data", 32'(inst_data), 32'(exp_dat));
            if (imem_rvalid) chk("rsp_expected", 32'(m_outst > 0), 32'd1);
`ifdef IFU_PERF_CNT_EN
            chk("perf_fetched", 32'(perf_fetched), 32'(m_pops));
            chk("perf_flushes", 32'(perf_flushes), 32'(m_flushes));
`endif
            if (rst && r2cyc >= 1 && r2cyc <= 4) begin
                e_wrap = 16'hFFFE + 16'(r2cyc - 1);
                chk("wrap_req", 32'(imem_req2), 32'd1);
                chk("wrap_addr", 32'(imem_addr2), 32'(e_wrap));
            end
            if (rst && r2cyc >= 3 && r2cyc <= 6) begin
                e_wrap = 16'hFFFE + 16'(r2cyc - 3);
                chk("wrap_valid", 32'(inst_valid2), 32'd1);
                chk("wrap_pc", 32'(inst_pc2), 32'(e_wrap));
                chk("wrap_data", 32'(inst_data2), 32'(mem_word(e_wrap)));
            end
        end

        // Environment: memory reacts to what the DUT actually did
        rv2_q   = imem_req2 && gnt2;
        addr2_q = imem_addr2;
        if (imem_rvalid) begin
            void'(mem_due.pop_front());
            void'(mem_addr.pop_front());
        end
        if (!rst) begin
            mem_due.delete(); mem_addr.delete(); last_due = 0;
        end else if (imem_req && imem_gnt) begin
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_due.push_back(due);
            mem_addr.push_back(imem_addr);
        end

        // Reference model update for this clock edge
        rsp = imem_rvalid && (m_outst > 0);
        pop = exp_vld && inst_ready;
        if (!rst) begin
            mq.delete(); m_fetch = 16'h0; m_resp = 16'h0; m_outst = 0;
            m_flush = 1'b0; m_pops = 16'h0; m_flushes = 16'h0;
        end else if (redirect) begin
            mq.delete();
            m_fetch = redirect_pc; m_resp = redirect_pc;
            m_outst -= int'(rsp);
            m_flush = (m_outst > 0);
            m_flushes++;
            if (pop) m_pops++;
        end else begin
            if (pop) begin
                void'(mq.pop_front());
                m_pops++;
            end
            if (rsp) begin
                m_outst--;
                if (!m_flush) begin
                    mq.push_back('{pc: m_resp, data: mem_word(m_resp)});
                    m_resp++;
                end else if (m_outst == 0) begin
                    m_flush = 1'b0;
                end
            end
            if (exp_req && imem_gnt) begin
                m_fetch++;
                m_outst++;
            end
        end
    endtask

    task automatic do_reset(input int n);
        rst_cmd = 1'b0;
        repeat (n) step();
        rst_cmd = 1'b1;
    endtask

    initial begin
        // First cycle: DUT registers still unknown, so no checks yet
        rst_cmd = 1'b0;
        step();
        chk_en = 1'b1;
        do_reset(2);

        // Streaming with single-cycle memory and no stalls
        repeat (20) step();

        // Core stall fills the queue, then drains in order
        p_ready = 0;
        repeat (10) step();
        p_ready = 100;
        repeat (10) step();

        // Grant withheld: request held at the same address
        p_gnt = 0;
        repeat (5) step();
        p_gnt = 100;
        repeat (10) step();

        // 3-cycle memory, redirect to 0040 with 3 reads in flight
        do_reset(2);
        lat_min = 3; lat_max = 3; arm_mode = 1;
        repeat (25) step();

        // Redirect coinciding with a response and a pop
        lat_min = 1; lat_max = 1; arm_mode = 2;
        repeat (25) step();

        // Randomized traffic with occasional mid-run resets
        for (int blk = 0; blk < 16; blk++) begin
            p_gnt   = $urandom_range(100, 30);
            p_ready = $urandom_range(100, 20);
            lat_min = $urandom_range(2, 1);
            lat_max = lat_min + $urandom_range(3, 0);
            p_redir = $urandom_range(60, 0);
            if (blk % 5 == 4) do_reset(2);
            repeat (200) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage sitting directly upstream of the single-cycle 16-bit core: owns the fetch PC, issues word reads to instruction memory over a request/grant/response handshake, and buffers returned instructions in a small prefetch queue. It presents one 16-bit instruction (with its PC) per cycle to the core over a valid/ready handshake. A redirect input (taken branch or jump) flushes the queue and discards in-flight responses.

## Interface
- DEPTH, 4, prefetch queue entries; power of two, ≥2
- RESET_PC, 16'h0000, fetch address after reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- imem_req  out  1  read request to instruction memory
- imem_addr  out  16  word address of request
- imem_gnt  in  1  request accepted this cycle (handshake = req & gnt)
- imem_rvalid  in  1  read data valid; responses return in order, one per granted request
- imem_rdata  in  16  instruction word
- redirect  in  1  flush and restart fetch
- redirect_pc  in  16  new fetch address, sampled when redirect=1
- inst_valid  out  1  inst_data/inst_pc valid
- inst_ready  in  1  core consumes instruction (pop = valid & ready)
- inst_data  out  16  instruction to core
- inst_pc  out  16  address of inst_data

## Operation
- States: FETCH, FLUSH. Reset → FETCH.
- Credit: occ (queue entries) + outst (granted, unanswered) ≤ DEPTH at all times.
- FETCH: imem_req = (occ + outst < DEPTH) & ~redirect; imem_addr = fetch_pc. On req & gnt: fetch_pc += 1 (16-bit wrap FFFF→0000), outst += 1.
- req/addr need not be held without gnt; they may drop or change.
- Response in FETCH: push {resp_pc, imem_rdata}; resp_pc += 1 (wrap); outst −= 1.
- Pop: head advances; push and pop in same cycle allowed, including when full.
- redirect (any state): queue cleared, fetch_pc = resp_pc = redirect_pc, discard = outst − (rvalid this cycle) + (req & gnt this cycle, always 0 since req masked); state → FLUSH if discard > 0, else FETCH. Response arriving in redirect cycle is dropped.
- FLUSH: no requests; each rvalid is dropped and decrements discard/outst; → FETCH when last discarded response arrives. Redirect in FLUSH only updates fetch_pc/resp_pc.
- rvalid with outst = 0: protocol violation, ignored (assertion in bench).

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, inst_valid 0, inst_data 0, inst_pc 0, occ 0, outst 0, state FETCH.
- First imem_req in first cycle with rst=1.
- Response at cycle N → inst_valid at N+1 (registered queue, no bypass).
- Redirect at cycle N → inst_valid 0 at N+1; first new request at N+1 if no discard, else cycle after last discarded response.
- Peak throughput one instruction/cycle with single-cycle gnt/rvalid.
- rst low mid-transfer: all state cleared; responses still in memory pipeline after reset are a system error (memory shares reset).

## Configuration
- IFU_PERF_CNT_EN defined: adds outputs perf_fetched (16, pops) and perf_flushes (16, redirects); both wrap, reset to 0.
- Not defined: ports and counters absent; functional behaviour identical.

## Structure
- Package ifu_pkg: XLEN=16, state enum (FETCH, FLUSH), PTR_W/CNT_W derivation from DEPTH.
- One sub-module: ifu_queue — circular buffer of {pc, inst}, push/pop/flush, occ output, full/empty.

## Test plan
- Reset, gnt=1, 1-cycle rvalid, ready=1 → addresses 0,1,2…; inst_pc 0,1,2 one per cycle from cycle 3.
- ready=0 for 10 cycles → exactly DEPTH(4) requests granted, queue full, req 0; ready=1 → in-order drain, no loss.
- gnt held 0 for 5 cycles → req stays 1 at addr 0, no fetch_pc advance.
- 3-cycle memory latency, 3 outstanding, redirect to 16'h0040 → 3 responses dropped, FLUSH until last, next req addr 0040, first inst_pc 0040.
- redirect coincident with rvalid and pop → response dropped, inst_valid 0 next cycle.
- RESET_PC=16'hFFFE → addresses FFFE, FFFF, 0000, 0001 (wrap).
